// File: rtl/serializer_if.sv
// Word-in / bit-out bundle between a word source and the serializer.
// The source drives iv_din/i_valid; the serializer drives everything else.
interface serializer_if #(
  parameter int LENGTH = 24
);
  logic [LENGTH-1:0] iv_din;
  logic              i_valid;
  logic              o_ready;
  logic              o_dout;
  logic              o_en;
  logic              o_tx_end;
  logic              o_busy;

  modport master (
    output iv_din, i_valid,
    input  o_ready, o_dout, o_en, o_tx_end, o_busy
  );

  modport slave (
    input  iv_din, i_valid,
    output o_ready, o_dout, o_en, o_tx_end, o_busy
  );
endinterface

// File: rtl/serializer.sv
// Parallel-to-serial transmitter: LSB-first data with a per-bit strobe and an
// end-of-word strobe, followed by GAP_BITS idle bit periods.
module serializer #(
  parameter int LENGTH       = 24,
  parameter int CLKS_PER_BIT = 4,
  parameter int GAP_BITS     = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  serializer_if.slave bus
);

  localparam int CLK_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_MAX = (LENGTH > GAP_BITS) ? LENGTH : GAP_BITS;
  localparam int BIT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;

  localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(LENGTH - 1);
  localparam logic [BIT_W-1:0] GAP_LAST = (GAP_BITS > 0) ? BIT_W'(GAP_BITS - 1) : '0;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t            state_q, state_d;
  logic [LENGTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CLK_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic              period_end;

  assign period_end = (clk_cnt_q == CLK_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      clk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      clk_cnt_q <= clk_cnt_d;
    end
  end

  // bit_cnt counts data bits in SHIFT and idle bit periods in GAP.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    clk_cnt_d = clk_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          shift_d   = bus.iv_din;
          bit_cnt_d = '0;
          clk_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (period_end) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = (GAP_BITS > 0) ? GAP : IDLE;
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (period_end) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == GAP_LAST) begin
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All outputs decode registered state only, so the strobes are glitch-free.
  assign bus.o_ready  = (state_q == IDLE);
  assign bus.o_busy   = (state_q != IDLE);
  assign bus.o_dout   = (state_q == SHIFT) ? shift_q[0] : 1'b0;
  assign bus.o_en     = (state_q == SHIFT) && period_end;
  assign bus.o_tx_end = (state_q == SHIFT) && period_end && (bit_cnt_q == BIT_LAST);

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer: default instance (4 clocks/bit, 1 gap bit)
// plus a 1 clock/bit, no-gap instance.
module tb_serializer;
  localparam int L = 24;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serializer_if #(.LENGTH(L)) bus_a ();
  serializer_if #(.LENGTH(L)) bus_b ();

  serializer #(.LENGTH(L), .CLKS_PER_BIT(4), .GAP_BITS(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_a.slave)
  );
  serializer #(.LENGTH(L), .CLKS_PER_BIT(1), .GAP_BITS(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_b.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic sample(input int sel, output logic en, output logic dout, output logic tx,
                        output logic rdy, output logic busy);
    if (sel == 0) begin
      en = bus_a.o_en; dout = bus_a.o_dout; tx = bus_a.o_tx_end;
      rdy = bus_a.o_ready; busy = bus_a.o_busy;
    end else begin
      en = bus_b.o_en; dout = bus_b.o_dout; tx = bus_b.o_tx_end;
      rdy = bus_b.o_ready; busy = bus_b.o_busy;
    end
  endtask

  task automatic drive(input int sel, input logic [L-1:0] w, input logic v);
    if (sel == 0) begin bus_a.iv_din = w; bus_a.i_valid = v; end
    else begin bus_b.iv_din = w; bus_b.i_valid = v; end
  endtask

  // Presents w with valid high; t is the edge number of the handshake.
  task automatic handshake(input int sel, input logic [L-1:0] w, output int t);
    logic en, dout, tx, rdy, busy;
    @(negedge clk);
    drive(sel, w, 1'b1);
    t = -1;
    for (int i = 0; i < 300; i++) begin
      sample(sel, en, dout, tx, rdy, busy);
      if (rdy) begin t = cyc + 1; break; end
      @(negedge clk);
    end
    if (t < 0) chk("handshake_timeout", 32'd0, 32'd1);
  endtask

  // Watches one word after handshake edge t; at each negedge the sampled values
  // are those seen by edge e = cyc+1.
  task automatic collect(input int sel, input int t, input int cpb, input int g,
                         input int poke, input bit keep, input logic [L-1:0] next_w,
                         output logic [L-1:0] word, output int n_en, output int bad,
                         output int n_tx, output int tx_edge, output int rdy_edge,
                         output int hs_next, output int n_gap_en);
    logic en, dout, tx, rdy, busy;
    int e;
    word = '0; n_en = 0; bad = 0; n_tx = 0; tx_edge = -1;
    rdy_edge = -1; hs_next = -1; n_gap_en = 0;
    for (int i = 0; i < (L + g) * cpb + 6; i++) begin
      @(negedge clk);
      e = cyc + 1;
      sample(sel, en, dout, tx, rdy, busy);
      if (en) begin
        if (e != t + (n_en + 1) * cpb) bad++;
        if (n_en < L) word[n_en] = dout;
        if (e > t + L * cpb) n_gap_en++;
        n_en++;
      end
      if (tx) begin
        n_tx++; tx_edge = e;
        if (!en) bad++;
      end
      if (rdy == busy) bad++;
      if (i == 0) begin
        if (keep) drive(sel, next_w, 1'b1);
        else drive(sel, next_w, 1'b0);
      end
      if (poke > 0 && e == t + poke) drive(sel, {L{1'b1}}, 1'b1);
      if (poke > 0 && e == t + poke + 1) drive(sel, {L{1'b1}}, 1'b0);
      if (rdy) begin
        rdy_edge = e - 1;
        if ((sel == 0) ? bus_a.i_valid : bus_b.i_valid) hs_next = e;
        break;
      end
    end
    if (rdy_edge < 0) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [L-1:0] word;
    logic en, dout, tx, rdy, busy;
    int t, t2, n_en, bad, n_tx, tx_edge, rdy_edge, hs_next, n_gap, errs;

    drive(0, '0, 1'b0);
    drive(1, '0, 1'b0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // 1: reset values, then 50 idle cycles
    #1;
    sample(0, en, dout, tx, rdy, busy);
    chk("rst_outputs", {27'd0, rdy, busy, en, tx, dout}, 32'b10000);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      sample(0, en, dout, tx, rdy, busy);
      if ({rdy, busy, en, tx, dout} !== 5'b10000) errs++;
    end
    chk("idle_hold_50", errs, 0);

    // 2: single word 24'hA5C3F0
    handshake(0, 24'hA5C3F0, t);
    collect(0, t, 4, 1, 0, 1'b0, '0, word, n_en, bad, n_tx, tx_edge, rdy_edge, hs_next, n_gap);
    chk("t2_en_count", n_en, 24);
    chk("t2_en_timing", bad, 0);
    chk("t2_first8", {24'd0, word[7:0]}, 32'h000000F0);
    chk("t2_word", {8'd0, word}, 32'h00A5C3F0);
    chk("t2_txend_cnt", n_tx, 1);
    chk("t2_txend_edge", tx_edge, t + 96);
    chk("t2_ready_edge", rdy_edge, t + 100);

    // 3: back-to-back with valid held
    handshake(0, 24'h000001, t);
    collect(0, t, 4, 1, 0, 1'b1, 24'h800000, word, n_en, bad, n_tx, tx_edge, rdy_edge,
            hs_next, n_gap);
    chk("t3_word1", {8'd0, word}, 32'h00000001);
    chk("t3_gap_quiet", n_gap, 0);
    chk("t3_hs2_edge", hs_next, t + 101);
    t2 = hs_next;
    collect(0, t2, 4, 1, 0, 1'b0, '0, word, n_en, bad, n_tx, tx_edge, rdy_edge, hs_next, n_gap);
    chk("t3_word2", {8'd0, word}, 32'h00800000);
    chk("t3_txend_edge", tx_edge, t2 + 96);
    chk("t3_timing", bad, 0);

    // 4: input change mid-word is ignored
    handshake(0, 24'h123456, t);
    collect(0, t, 4, 1, 30, 1'b0, 24'h123456, word, n_en, bad, n_tx, tx_edge, rdy_edge,
            hs_next, n_gap);
    chk("t4_word", {8'd0, word}, 32'h00123456);
    chk("t4_ready_edge", rdy_edge, t + 100);
    drive(0, '0, 1'b0);

    // 5: async reset during bit 10
    handshake(0, 24'hFFFFFF, t);
    errs = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 0) drive(0, '0, 1'b0);
      sample(0, en, dout, tx, rdy, busy);
      if (tx) errs++;
      if (cyc + 1 == t + 44) break;
    end
    chk("t5_bit10_en", {30'd0, en, dout}, 32'b11);
    #1 rst_n = 1'b0;
    #1;
    sample(0, en, dout, tx, rdy, busy);
    chk("t5_async_clear", {27'd0, rdy, busy, en, tx, dout}, 32'b10000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sample(0, en, dout, tx, rdy, busy);
      if (tx) errs++;
    end
    chk("t5_no_txend", errs, 0);
    rst_n = 1'b1;
    handshake(0, 24'h00000F, t);
    collect(0, t, 4, 1, 0, 1'b0, '0, word, n_en, bad, n_tx, tx_edge, rdy_edge, hs_next, n_gap);
    chk("t5_word", {8'd0, word}, 32'h0000000F);
    chk("t5_txend_edge", tx_edge, t + 96);

    // 6: one clock per bit, no gap
    handshake(1, 24'hFFFFFF, t);
    collect(1, t, 1, 0, 0, 1'b1, 24'h000000, word, n_en, bad, n_tx, tx_edge, rdy_edge,
            hs_next, n_gap);
    chk("t6_en_count", n_en, 24);
    chk("t6_en_timing", bad, 0);
    chk("t6_word", {8'd0, word}, 32'h00FFFFFF);
    chk("t6_txend_edge", tx_edge, t + 24);
    chk("t6_next_hs", hs_next, t + 25);
    t2 = hs_next;
    collect(1, t2, 1, 0, 0, 1'b0, '0, word, n_en, bad, n_tx, tx_edge, rdy_edge, hs_next, n_gap);
    chk("t6_word2", {8'd0, word}, 32'h00000000);
    chk("t6_word2_en", n_en, 24);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
Parallel-to-serial transmit stage feeding the FIR filter's serial receive path. It accepts a LENGTH-bit sample through a valid/ready handshake. It shifts the sample out LSB-first, one bit per bit period, on a single data line. Alongside the data it produces a per-bit enable strobe and an end-of-word strobe, so a downstream deserializer can reassemble the word without any extra framing logic.

Parameters:
LENGTH, 24, bits per word; legal range >= 2.
CLKS_PER_BIT, 4, i_clk cycles per serial bit period; legal range >= 1.
GAP_BITS, 1, idle bit periods inserted after each word; legal range >= 0.

Ports:
i_clk  input  1  system clock, rising edge.
i_rst_n  input  1  asynchronous, active-low reset.
iv_din  input  LENGTH  parallel word to transmit; sampled only on a handshake.
i_valid  input  1  iv_din holds a word to send.
o_ready  output  1  block can accept a word; equals (state == IDLE).
o_dout  output  1  serial data, LSB first.
o_en  output  1  one-cycle bit strobe; o_dout is valid whenever o_en is high.
o_tx_end  output  1  high together with o_en on the last bit (bit LENGTH-1) only.
o_busy  output  1  equals (state != IDLE).

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - state goes to IDLE; shift register, bit counter and clock counter clear to 0.
  - Outputs take these values immediately: o_dout=0, o_en=0, o_tx_end=0, o_busy=0, o_ready=1.
  - A reset mid-word aborts that word; no partial o_tx_end is ever produced.
- State machine: IDLE -> SHIFT -> GAP -> IDLE. When GAP_BITS=0, SHIFT goes directly to IDLE.
- IDLE:
  - o_dout=0.
  - Handshake = i_valid && o_ready at a rising edge.
  - On the handshake edge: load iv_din into the shift register, clear bit_cnt and clk_cnt, move to SHIFT.
- SHIFT:
  - o_dout = shift_reg[0], held stable for the whole bit period.
  - clk_cnt counts 0..CLKS_PER_BIT-1 and wraps.
  - o_en is high for exactly the one cycle where clk_cnt == CLKS_PER_BIT-1. o_en is a decode of registered state only, so it is glitch-free.
  - At the end of each bit period: if bit_cnt == LENGTH-1, assert o_tx_end in that same cycle and move to GAP (or IDLE). Otherwise shift the register right by one and increment bit_cnt.
  - With CLKS_PER_BIT=1, o_en is high on every SHIFT cycle (LENGTH consecutive cycles).
- GAP:
  - o_dout=0, o_en=0.
  - Lasts GAP_BITS*CLKS_PER_BIT cycles, then moves to IDLE.
- Timing, for a handshake at edge T:
  - bit 0 appears on o_dout after edge T.
  - First o_en is sampled at edge T+CLKS_PER_BIT.
  - Bit k's o_en is sampled at edge T+(k+1)*CLKS_PER_BIT.
  - Last o_en (with o_tx_end) is sampled at edge T+LENGTH*CLKS_PER_BIT.
  - IDLE is re-entered at edge T+(LENGTH+GAP_BITS)*CLKS_PER_BIT.
  - Earliest next handshake is one edge after that. Minimum word spacing is (LENGTH+GAP_BITS)*CLKS_PER_BIT+1 cycles.
- i_valid and iv_din are ignored outside IDLE. The caller holds iv_din until the handshake; there is no internal input buffer.
- Counter widths are $clog2 of their ranges, minimum 1 bit. No arithmetic overflow is possible within the legal parameter ranges.

Test Plan:
1. Assert i_rst_n=0, then release with i_valid=0 -> o_ready=1; o_busy, o_en, o_tx_end and o_dout all 0; they stay that way for 50 cycles.
2. Defaults; one handshake with iv_din=24'hA5C3F0 at edge T:
   - 24 o_en pulses, sampled at T+4, T+8, ..., T+96.
   - The first 8 bits sampled on o_en are 0,0,0,0,1,1,1,1.
   - A bench reassembling the word LSB-first gets 24'hA5C3F0.
   - o_tx_end is high only at T+96.
   - o_ready returns high at T+100.
3. Defaults; i_valid held high with words 24'h000001 then 24'h800000:
   - Handshakes occur at T and T+101.
   - Bit 0 of the first word is 1; bit 23 of the second word is 1 and arrives with o_tx_end; all other bits are 0.
   - No o_en pulses during T+97..T+100.
4. Defaults; after handshaking 24'h123456, change iv_din to 24'hFFFFFF and pulse i_valid mid-word -> the serialized word is still 24'h123456, and o_ready stays low until T+100.
5. Defaults; drop i_rst_n asynchronously during bit 10 -> o_en, o_dout and o_busy go to 0 before the next clock edge; no o_tx_end occurs. After release, word 24'h00000F transmits cleanly with its o_tx_end at T'+96.
6. CLKS_PER_BIT=1, GAP_BITS=0, word 24'hFFFFFF at edge T -> o_en high for the 24 consecutive cycles sampled at edges T+1..T+24, o_tx_end at T+24, next handshake accepted at T+25.
